// File: rtl/i2s_apb_stream_master.sv
// APB master feeding I2S_top: programs the control word once, then turns a
// TX sample stream into data-register writes and RX read requests into a stream.
module i2s_apb_stream_master #(
  parameter logic [31:0] CFG_ADDR = 32'h0,
  parameter logic [31:0] TX_ADDR  = 32'h4,
  parameter logic [31:0] RX_ADDR  = 32'h18
) (
  input  logic        pclk,
  input  logic        preset,
  input  logic        start,
  input  logic        stop,
  input  logic [31:0] cfg_word,
  input  logic        s_valid,
  input  logic [31:0] s_data,
  output logic        s_ready,
  input  logic        rx_req,
  output logic        m_valid,
  output logic [31:0] m_data,
  input  logic        m_ready,
  output logic        penable,
  output logic        pwrite,
  output logic [31:0] paddr,
  output logic [31:0] pwdata,
  input  logic [31:0] prdata,
  output logic        busy,
  output logic        rx_miss,
  output logic        rx_ovf
);

  typedef enum logic [2:0] {IDLE, CFG_S, CFG_A, RUN, WR_S, WR_A, RD_S, RD_A} state_t;

  state_t      state, state_nx;
  logic [31:0] tx_buf;
  logic        tx_full, rx_pend, last_was_rd, stop_pend;
  logic [31:0] fifo_mem [2];
  logic        wr_ptr, rd_ptr;
  logic [1:0]  fifo_cnt;

  logic        active, tx_hs, tx_want, rx_new, rd_want, stop_eff;
  logic        push, pop, fifo_full, do_push;
  logic        penable_d, pwrite_d;
  logic [31:0] paddr_d, pwdata_d;

  assign active    = (state != IDLE);
  assign busy      = active;
  assign s_ready   = active & ~tx_full;
  assign tx_hs     = s_valid & s_ready;
  // Same-cycle requests count so RUN can dispatch without an extra idle cycle
  assign tx_want   = tx_full | tx_hs;
  assign rx_new    = rx_req & active & ~rx_pend;
  assign rd_want   = rx_pend | rx_new;
  assign stop_eff  = stop_pend | stop;

  assign push      = (state == RD_A);
  assign pop       = m_valid & m_ready;
  assign fifo_full = (fifo_cnt == 2'd2);
  assign do_push   = push & (~fifo_full | pop);
  assign m_valid   = (fifo_cnt != 2'd0);
  assign m_data    = fifo_mem[rd_ptr];

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:  if (start) state_nx = CFG_S;
      CFG_S: state_nx = CFG_A;
      CFG_A: state_nx = stop_eff ? IDLE : RUN;
      RUN: begin
        if (stop_eff)                state_nx = IDLE;
        else if (rd_want && tx_want) state_nx = last_was_rd ? WR_S : RD_S;
        else if (rd_want)            state_nx = RD_S;
        else if (tx_want)            state_nx = WR_S;
      end
      WR_S:  state_nx = WR_A;
      RD_S:  state_nx = RD_A;
      WR_A,
      RD_A:  state_nx = stop_eff ? IDLE : RUN;
      default: state_nx = IDLE;
    endcase
  end

  // APB outputs are registered from the next state; the pwdata register itself
  // holds the latched control word for the whole CFG transfer.
  always_comb begin
    penable_d = 1'b0;
    pwrite_d  = 1'b0;
    paddr_d   = paddr;
    pwdata_d  = pwdata;
    case (state_nx)
      CFG_S: begin
        pwrite_d = 1'b1;
        paddr_d  = CFG_ADDR;
        pwdata_d = cfg_word;
      end
      WR_S: begin
        pwrite_d = 1'b1;
        paddr_d  = TX_ADDR;
        pwdata_d = tx_full ? tx_buf : s_data;
      end
      RD_S: paddr_d = RX_ADDR;
      CFG_A, WR_A: begin
        penable_d = 1'b1;
        pwrite_d  = 1'b1;
      end
      RD_A: penable_d = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge pclk) begin
    if (preset) begin
      state   <= IDLE;
      penable <= 1'b0;
      pwrite  <= 1'b0;
      paddr   <= '0;
      pwdata  <= '0;
    end else begin
      state   <= state_nx;
      penable <= penable_d;
      pwrite  <= pwrite_d;
      paddr   <= paddr_d;
      pwdata  <= pwdata_d;
    end
  end

  always_ff @(posedge pclk) begin
    if (preset) begin
      tx_full     <= 1'b0;
      tx_buf      <= '0;
      rx_pend     <= 1'b0;
      last_was_rd <= 1'b0;
      stop_pend   <= 1'b0;
      rx_miss     <= 1'b0;
    end else begin
      if (state_nx == IDLE || state == WR_A) begin
        tx_full <= 1'b0;
      end else if (tx_hs) begin
        tx_full <= 1'b1;
        tx_buf  <= s_data;
      end

      if (state_nx == IDLE || state == RD_A) rx_pend <= 1'b0;
      else if (rx_new)                       rx_pend <= 1'b1;

      if (state_nx == RD_S)      last_was_rd <= 1'b1;
      else if (state_nx == WR_S) last_was_rd <= 1'b0;

      if (state_nx == IDLE)    stop_pend <= 1'b0;
      else if (stop && active) stop_pend <= 1'b1;

      if (rx_req && active && rx_pend) rx_miss <= 1'b1;
    end
  end

  always_ff @(posedge pclk) begin
    if (preset) begin
      for (int unsigned i = 0; i < 2; i++) fifo_mem[i] <= '0;
      wr_ptr   <= 1'b0;
      rd_ptr   <= 1'b0;
      fifo_cnt <= '0;
      rx_ovf   <= 1'b0;
    end else begin
      if (do_push) begin
        fifo_mem[wr_ptr] <= prdata;
        wr_ptr           <= ~wr_ptr;
      end
      if (pop) rd_ptr <= ~rd_ptr;
      fifo_cnt <= fifo_cnt + {1'b0, do_push} - {1'b0, pop};
      if (push && fifo_full && !pop) rx_ovf <= 1'b1;
    end
  end

endmodule

// File: tb/tb_i2s_apb_stream_master.sv
// Directed self-checking bench for i2s_apb_stream_master with an APB slave model.
module tb_i2s_apb_stream_master;

  logic        pclk = 1'b0;
  logic        preset, start, stop, s_valid, rx_req, m_ready;
  logic [31:0] cfg_word, s_data, prdata;
  logic        s_ready, m_valid, penable, pwrite, busy, rx_miss, rx_ovf;
  logic [31:0] m_data, paddr, pwdata;

  int tests = 0;
  int fails = 0;

  i2s_apb_stream_master #(
    .CFG_ADDR(32'h0),
    .TX_ADDR (32'h4),
    .RX_ADDR (32'h18)
  ) dut (
    .pclk(pclk), .preset(preset), .start(start), .stop(stop), .cfg_word(cfg_word),
    .s_valid(s_valid), .s_data(s_data), .s_ready(s_ready), .rx_req(rx_req),
    .m_valid(m_valid), .m_data(m_data), .m_ready(m_ready), .penable(penable),
    .pwrite(pwrite), .paddr(paddr), .pwdata(pwdata), .prdata(prdata),
    .busy(busy), .rx_miss(rx_miss), .rx_ovf(rx_ovf)
  );

  always #5 pclk = ~pclk;

  // APB slave: logs writes and transfer types, returns an incrementing read counter
  logic [63:0] wq[$];
  bit          tq[$];
  logic [31:0] rd_cnt = 32'h100;
  int          viol = 0;
  logic        prev_en = 1'b0, prev_wr = 1'b0;
  logic [31:0] prev_addr = '0;
  assign prdata = rd_cnt;

  always @(posedge pclk) begin
    if (penable === 1'b1) begin
      if (prev_en || prev_addr !== paddr || prev_wr !== pwrite) viol++;
      tq.push_back(pwrite);
      if (pwrite) wq.push_back({paddr, pwdata});
      else        rd_cnt <= rd_cnt + 32'd1;
    end
    prev_en   <= penable;
    prev_wr   <= pwrite;
    prev_addr <= paddr;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge pclk);
      #1;
    end
  endtask

  task automatic test_reset();
    preset = 1'b1;
    tick(2);
    tests++; if (penable !== 1'b0) begin fails++; $display("FAIL rst_penable: got %b want 0", penable); end
    tests++; if (pwrite  !== 1'b0) begin fails++; $display("FAIL rst_pwrite: got %b want 0", pwrite); end
    tests++; if (paddr   !== 32'h0) begin fails++; $display("FAIL rst_paddr: got %h want 0", paddr); end
    tests++; if (pwdata  !== 32'h0) begin fails++; $display("FAIL rst_pwdata: got %h want 0", pwdata); end
    tests++; if (s_ready !== 1'b0) begin fails++; $display("FAIL rst_s_ready: got %b want 0", s_ready); end
    tests++; if (m_valid !== 1'b0) begin fails++; $display("FAIL rst_m_valid: got %b want 0", m_valid); end
    tests++; if (m_data  !== 32'h0) begin fails++; $display("FAIL rst_m_data: got %h want 0", m_data); end
    tests++; if (busy    !== 1'b0) begin fails++; $display("FAIL rst_busy: got %b want 0", busy); end
    tests++; if ({rx_miss, rx_ovf} !== 2'b00) begin fails++; $display("FAIL rst_flags: got %b want 00", {rx_miss, rx_ovf}); end
    preset = 1'b0;
    // Inputs ignored in IDLE
    s_valid = 1'b1; rx_req = 1'b1; stop = 1'b1;
    tick(2);
    s_valid = 1'b0; rx_req = 1'b0; stop = 1'b0;
    tests++; if ({busy, penable, pwrite} !== 3'b000) begin fails++; $display("FAIL idle_ignore: got %b want 000", {busy, penable, pwrite}); end
  endtask

  task automatic test_config();
    wq.delete();
    cfg_word = 32'h0000_0121;
    start = 1'b1;
    tick();
    start = 1'b0;
    cfg_word = 32'hDEAD_BEEF;
    tests++; if ({penable, pwrite, busy} !== 3'b011) begin fails++; $display("FAIL cfg_s_ctrl: got %b want 011", {penable, pwrite, busy}); end
    tests++; if (paddr !== 32'h0) begin fails++; $display("FAIL cfg_s_addr: got %h want 0", paddr); end
    tests++; if (pwdata !== 32'h121) begin fails++; $display("FAIL cfg_s_data: got %h want 121", pwdata); end
    tick();
    tests++; if ({penable, pwrite} !== 2'b11) begin fails++; $display("FAIL cfg_a_ctrl: got %b want 11", {penable, pwrite}); end
    tests++; if (pwdata !== 32'h121) begin fails++; $display("FAIL cfg_a_data: got %h want 121", pwdata); end
    tick();
    tests++; if ({penable, pwrite, s_ready} !== 3'b001) begin fails++; $display("FAIL cfg_run: got %b want 001", {penable, pwrite, s_ready}); end
    tests++; if (wq.size() != 1 || wq[0] !== {32'h0, 32'h121}) begin fails++; $display("FAIL cfg_log: got %0d writes want 1 of 0/121", wq.size()); end
    start = 1'b1;
    tick();
    start = 1'b0;
    tests++; if ({penable, pwrite, busy} !== 3'b001) begin fails++; $display("FAIL start_in_run: got %b want 001", {penable, pwrite, busy}); end
    tick(2);
  endtask

  task automatic test_tx_latency();
    s_valid = 1'b1;
    s_data  = 32'hA5A5_0001;
    tests++; if (s_ready !== 1'b1) begin fails++; $display("FAIL tx_ready_idle: got %b want 1", s_ready); end
    tick();
    s_valid = 1'b0;
    tests++; if ({penable, pwrite, s_ready} !== 3'b010) begin fails++; $display("FAIL tx_wr_s: got %b want 010", {penable, pwrite, s_ready}); end
    tests++; if (paddr !== 32'h4 || pwdata !== 32'hA5A5_0001) begin fails++; $display("FAIL tx_wr_s_bus: got %h/%h want 4/a5a50001", paddr, pwdata); end
    tick();
    tests++; if ({penable, pwrite} !== 2'b11) begin fails++; $display("FAIL tx_wr_a: got %b want 11", {penable, pwrite}); end
    tick();
    tests++; if ({penable, s_ready} !== 2'b01) begin fails++; $display("FAIL tx_ready_again: got %b want 01", {penable, s_ready}); end
  endtask

  task automatic test_stream();
    logic [31:0] exp_d [20];
    int idx = 0;
    int cyc = 0;
    int bad = 0;
    int v0;
    logic hs;
    for (int i = 0; i < 20; i++) exp_d[i] = $urandom;
    wq.delete();
    v0 = viol;
    s_valid = 1'b1;
    while (idx < 20 && cyc < 200) begin
      s_data = exp_d[idx];
      hs = s_ready;
      tick();
      cyc++;
      if (hs) idx++;
    end
    s_valid = 1'b0;
    tick(4);
    tests++; if (idx != 20) begin fails++; $display("FAIL stream_accept: got %0d want 20", idx); end
    tests++; if (cyc != 58) begin fails++; $display("FAIL stream_rate: got %0d cycles want 58", cyc); end
    tests++; if (wq.size() != 20) begin fails++; $display("FAIL stream_count: got %0d want 20", wq.size()); end
    for (int i = 0; i < 20; i++)
      if (i >= wq.size() || wq[i] !== {32'h4, exp_d[i]}) bad++;
    tests++; if (bad != 0) begin fails++; $display("FAIL stream_data: got %0d bad entries want 0", bad); end
    tests++; if (viol != v0) begin fails++; $display("FAIL stream_protocol: got %0d violations want 0", viol - v0); end
  endtask

  task automatic test_interleave();
    logic [31:0] mq[$];
    int k = 0;
    int nrd = 0;
    int alt_err = 0;
    int mono_err = 0;
    int dat_err = 0;
    logic hs;
    wq.delete();
    tq.delete();
    m_ready = 1'b1;
    for (int c = 0; c < 36; c++) begin
      s_valid = 1'b1;
      s_data  = 32'h5000_0000 + k;
      rx_req  = (c % 6 == 0);
      if (m_valid) mq.push_back(m_data);
      hs = s_ready;
      tick();
      if (hs) k++;
    end
    s_valid = 1'b0;
    rx_req  = 1'b0;
    for (int c = 0; c < 12; c++) begin
      if (m_valid) mq.push_back(m_data);
      tick();
    end
    foreach (tq[i]) if (!tq[i]) nrd++;
    for (int i = 1; i < 10; i++) if (i < tq.size() && tq[i] == tq[i-1]) alt_err++;
    for (int i = 1; i < mq.size(); i++) if (mq[i] <= mq[i-1]) mono_err++;
    foreach (wq[i]) if (wq[i] !== {32'h4, 32'h5000_0000 + i}) dat_err++;
    tests++; if (rx_miss !== 1'b0) begin fails++; $display("FAIL mix_rx_miss: got %b want 0", rx_miss); end
    tests++; if (nrd != 6) begin fails++; $display("FAIL mix_reads: got %0d want 6", nrd); end
    tests++; if (tq.size() < 10 || alt_err != 0) begin fails++; $display("FAIL mix_alternate: got %0d repeats of %0d xfers want 0", alt_err, tq.size()); end
    tests++; if (mq.size() != 6 || mono_err != 0) begin fails++; $display("FAIL mix_m_data: got %0d outputs %0d non-monotonic want 6/0", mq.size(), mono_err); end
    tests++; if (wq.size() < 6 || dat_err != 0) begin fails++; $display("FAIL mix_wdata: got %0d bad of %0d writes want 0", dat_err, wq.size()); end
  endtask

  task automatic test_overflow();
    logic [31:0] exp_v [3];
    logic [31:0] outs[$];
    m_ready = 1'b0;
    for (int r = 0; r < 3; r++) begin
      exp_v[r] = rd_cnt;
      rx_req = 1'b1;
      tick();
      rx_req = 1'b0;
      if (r == 0) begin
        tests++; if ({penable, pwrite} !== 2'b00 || paddr !== 32'h18) begin fails++; $display("FAIL rd_s: got %b/%h want 00/18", {penable, pwrite}, paddr); end
      end
      tick();
      if (r == 0) begin
        tests++; if ({penable, pwrite} !== 2'b10) begin fails++; $display("FAIL rd_a: got %b want 10", {penable, pwrite}); end
      end
      tick();
      if (r == 0) begin
        tests++; if (m_valid !== 1'b1 || m_data !== exp_v[0]) begin fails++; $display("FAIL rd_latency: got %b/%h want 1/%h", m_valid, m_data, exp_v[0]); end
      end
      if (r == 1) begin
        tests++; if (rx_ovf !== 1'b0) begin fails++; $display("FAIL ovf_early: got %b want 0", rx_ovf); end
      end
      tick();
    end
    tests++; if (rx_ovf !== 1'b1) begin fails++; $display("FAIL ovf_set: got %b want 1", rx_ovf); end
    tests++; if (m_data !== exp_v[0]) begin fails++; $display("FAIL ovf_head: got %h want %h", m_data, exp_v[0]); end
    m_ready = 1'b1;
    for (int c = 0; c < 5; c++) begin
      if (m_valid) outs.push_back(m_data);
      tick();
    end
    tests++; if (outs.size() != 2) begin fails++; $display("FAIL ovf_drain_count: got %0d want 2", outs.size()); end
    tests++; if (outs.size() < 2 || outs[0] !== exp_v[0] || outs[1] !== exp_v[1]) begin fails++; $display("FAIL ovf_drain_data: got %0d entries want %h,%h", outs.size(), exp_v[0], exp_v[1]); end
  endtask

  task automatic test_stop_miss();
    wq.delete();
    s_valid = 1'b1;
    s_data  = 32'h0000_0033;
    tick();
    s_valid = 1'b0;
    stop    = 1'b1;
    rx_req  = 1'b1;
    tests++; if ({penable, pwrite} !== 2'b01) begin fails++; $display("FAIL stop_wr_s: got %b want 01", {penable, pwrite}); end
    tick();
    stop = 1'b0;
    tests++; if ({penable, busy, rx_miss} !== 3'b110) begin fails++; $display("FAIL stop_wr_a: got %b want 110", {penable, busy, rx_miss}); end
    tick();
    rx_req = 1'b0;
    tests++; if ({busy, penable, s_ready} !== 3'b000) begin fails++; $display("FAIL stop_idle: got %b want 000", {busy, penable, s_ready}); end
    tests++; if (rx_miss !== 1'b1) begin fails++; $display("FAIL rx_miss_set: got %b want 1", rx_miss); end
    tests++; if (wq.size() != 1 || wq[0] !== {32'h4, 32'h33}) begin fails++; $display("FAIL stop_write: got %0d writes want 1 of 4/33", wq.size()); end
    tick(3);
    tests++; if ({busy, penable} !== 2'b00) begin fails++; $display("FAIL stop_stays_idle: got %b want 00", {busy, penable}); end
  endtask

  task automatic test_reset_mid();
    cfg_word = 32'h0000_0121;
    start = 1'b1;
    tick();
    start = 1'b0;
    tick(2);
    s_valid = 1'b1;
    s_data  = 32'h0000_0077;
    tick();
    s_valid = 1'b0;
    tick();
    tests++; if ({penable, pwrite} !== 2'b11) begin fails++; $display("FAIL rmid_pre: got %b want 11", {penable, pwrite}); end
    preset = 1'b1;
    tick();
    preset = 1'b0;
    tests++; if ({penable, pwrite, busy, s_ready} !== 4'b0000) begin fails++; $display("FAIL rmid_ctrl: got %b want 0000", {penable, pwrite, busy, s_ready}); end
    tests++; if ({rx_miss, rx_ovf, m_valid} !== 3'b000) begin fails++; $display("FAIL rmid_flags: got %b want 000", {rx_miss, rx_ovf, m_valid}); end
    tests++; if (paddr !== 32'h0 || pwdata !== 32'h0) begin fails++; $display("FAIL rmid_bus: got %h/%h want 0/0", paddr, pwdata); end
    tick(2);
    tests++; if ({penable, busy} !== 2'b00) begin fails++; $display("FAIL rmid_no_retry: got %b want 00", {penable, busy}); end
  endtask

  initial begin
    preset = 1'b1; start = 1'b0; stop = 1'b0; cfg_word = '0;
    s_valid = 1'b0; s_data = '0; rx_req = 1'b0; m_ready = 1'b0;
    test_reset();
    test_config();
    test_tx_latency();
    test_stream();
    test_interleave();
    test_overflow();
    test_stop_miss();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
